// File: rtl/br_issue_sched.sv
// Branch issue scheduler: compacting age-ordered queue that issues one
// branch at a time into a single branch unit and wakes up sources off the CDB.
package br_issue_sched_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic        bp;
    logic [31:0] bp_addr;
    logic [7:0]  gshare;
    logic [1:0]  pht_value;
  } decode_info_t;
endpackage

// Per-entry source wakeup: tag 0 is hard-wired ready.
module br_sched_wake #(
  parameter int PHYS_REG_BITS = 6
) (
  input  logic [PHYS_REG_BITS-1:0] prs1_i,
  input  logic [PHYS_REG_BITS-1:0] prs2_i,
  input  logic                     rdy1_i,
  input  logic                     rdy2_i,
  input  logic                     cdb_valid_i,
  input  logic [PHYS_REG_BITS-1:0] cdb_pd_i,
  output logic                     rdy1_o,
  output logic                     rdy2_o
);
  assign rdy1_o = rdy1_i | (prs1_i == '0) | (cdb_valid_i && (cdb_pd_i == prs1_i));
  assign rdy2_o = rdy2_i | (prs2_i == '0) | (cdb_valid_i && (cdb_pd_i == prs2_i));
endmodule

module br_issue_sched
  import br_issue_sched_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int PHYS_REG_BITS = 6,
  parameter int ROB_IDX_BITS  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_valid,
  output logic                      alloc_ready,
  input  decode_info_t              alloc_decode,
  input  logic [PHYS_REG_BITS-1:0]  alloc_prs1,
  input  logic [PHYS_REG_BITS-1:0]  alloc_prs2,
  input  logic                      alloc_rs1_rdy,
  input  logic                      alloc_rs2_rdy,
  input  logic [ROB_IDX_BITS-1:0]   alloc_rob_idx,
  input  logic                      cdb_valid,
  input  logic [PHYS_REG_BITS-1:0]  cdb_pd,
  output logic                      issue_start,
  output decode_info_t              issue_decode,
  output logic [PHYS_REG_BITS-1:0]  issue_prs1,
  output logic [PHYS_REG_BITS-1:0]  issue_prs2,
  output logic [ROB_IDX_BITS-1:0]   issue_rob_idx,
  input  logic                      fu_valid,
  input  logic                      flush,
  output logic                      inflight,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [PHYS_REG_BITS-1:0] prs1;
    logic [PHYS_REG_BITS-1:0] prs2;
    logic [ROB_IDX_BITS-1:0]  rob;
    decode_info_t             dec;
  } pay_t;

  typedef struct packed {
    logic vld;
    logic rdy1;
    logic rdy2;
    pay_t p;
  } ent_t;

  ent_t             ent_q   [DEPTH];
  ent_t             ent_ext [DEPTH+1];
  pay_t             pay_or  [DEPTH+1];
  ent_t             alloc_ent;
  logic [DEPTH-1:0] rdy_vec, sel_oh;
  logic [DEPTH:0]   any_below;
  logic [CW-1:0]    count_q, count_d, cnt_after;
  logic             inflight_q, inflight_d;
  logic             start_q, start_d;
  pay_t             pay_q, pay_d;
  logic             do_issue, alloc_fire;

  assign alloc_ready = !rst && !flush && (count_q < DEPTH_C);
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign do_issue    = !inflight_q && !flush && any_below[DEPTH];
  assign cnt_after   = count_q - CW'(do_issue);

  assign alloc_ent.vld    = 1'b1;
  assign alloc_ent.rdy1   = alloc_rs1_rdy;
  assign alloc_ent.rdy2   = alloc_rs2_rdy;
  assign alloc_ent.p.prs1 = alloc_prs1;
  assign alloc_ent.p.prs2 = alloc_prs2;
  assign alloc_ent.p.rob  = alloc_rob_idx;
  assign alloc_ent.p.dec  = alloc_decode;

  assign any_below[0]   = 1'b0;
  assign pay_or[0]      = '0;
  assign ent_ext[DEPTH] = '0;

  for (genvar g = 0; g < DEPTH; g++) begin : g_lane
    ent_t sh, ent_d;
    logic wk1, wk2;

    assign ent_ext[g]     = ent_q[g];
    assign rdy_vec[g]     = ent_q[g].vld & ent_q[g].rdy1 & ent_q[g].rdy2;
    assign any_below[g+1] = any_below[g] | rdy_vec[g];
    assign sel_oh[g]      = rdy_vec[g] & ~any_below[g];
    assign pay_or[g+1]    = pay_or[g] | ({$bits(pay_t){sel_oh[g]}} & ent_q[g].p);

    // Lanes at or above the issued slot pull from the next-younger entry;
    // the new op lands at the post-compaction tail.
    always_comb begin
      sh = (do_issue && any_below[g+1]) ? ent_ext[g+1] : ent_q[g];
      if (alloc_fire && (cnt_after == CW'(g))) sh = alloc_ent;
    end

    br_sched_wake #(.PHYS_REG_BITS(PHYS_REG_BITS)) u_wake (
      .prs1_i      (sh.p.prs1),
      .prs2_i      (sh.p.prs2),
      .rdy1_i      (sh.rdy1),
      .rdy2_i      (sh.rdy2),
      .cdb_valid_i (cdb_valid),
      .cdb_pd_i    (cdb_pd),
      .rdy1_o      (wk1),
      .rdy2_o      (wk2)
    );

    always_comb begin
      ent_d      = sh;
      ent_d.rdy1 = wk1;
      ent_d.rdy2 = wk2;
      if (flush) ent_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) ent_q[g] <= '0;
      else     ent_q[g] <= ent_d;
    end
  end

  always_comb begin
    count_d    = cnt_after + CW'(alloc_fire);
    inflight_d = inflight_q;
    start_d    = do_issue;
    pay_d      = do_issue ? pay_or[DEPTH] : pay_q;
    if (do_issue)                    inflight_d = 1'b1;
    else if (fu_valid && inflight_q) inflight_d = 1'b0;
    if (flush) begin
      count_d    = '0;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      inflight_q <= 1'b0;
      start_q    <= 1'b0;
      pay_q      <= '0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      start_q    <= start_d;
      pay_q      <= pay_d;
    end
  end

  assign count         = count_q;
  assign inflight      = inflight_q;
  assign issue_start   = start_q;
  assign issue_decode  = pay_q.dec;
  assign issue_prs1    = pay_q.prs1;
  assign issue_prs2    = pay_q.prs2;
  assign issue_rob_idx = pay_q.rob;
endmodule

// File: tb/tb_br_issue_sched.sv
// Randomized + directed bench: queue-based reference model feeds an issue
// scoreboard that a separate monitor drains on every issue_start pulse.
module tb_br_issue_sched;
  import br_issue_sched_pkg::*;
  localparam int DEPTH = 4;
  localparam int PW    = 6;
  localparam int RW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic alloc_valid, alloc_ready, alloc_rs1_rdy, alloc_rs2_rdy;
  decode_info_t alloc_decode, issue_decode;
  logic [PW-1:0] alloc_prs1, alloc_prs2, cdb_pd, issue_prs1, issue_prs2;
  logic [RW-1:0] alloc_rob_idx, issue_rob_idx;
  logic cdb_valid, issue_start, fu_valid, flush, inflight;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  br_issue_sched #(.DEPTH(DEPTH), .PHYS_REG_BITS(PW), .ROB_IDX_BITS(RW)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_decode(alloc_decode),
    .alloc_prs1(alloc_prs1), .alloc_prs2(alloc_prs2),
    .alloc_rs1_rdy(alloc_rs1_rdy), .alloc_rs2_rdy(alloc_rs2_rdy),
    .alloc_rob_idx(alloc_rob_idx), .cdb_valid(cdb_valid), .cdb_pd(cdb_pd),
    .issue_start(issue_start), .issue_decode(issue_decode),
    .issue_prs1(issue_prs1), .issue_prs2(issue_prs2), .issue_rob_idx(issue_rob_idx),
    .fu_valid(fu_valid), .flush(flush), .inflight(inflight), .count(count)
  );

  typedef struct {
    logic [RW-1:0] rob;
    logic [PW-1:0] p1, p2;
    bit            r1, r2;
    decode_info_t  dec;
    int            cyc;
  } op_t;

  op_t q[$];      // model queue, oldest first
  op_t exp_q[$];  // expected issues in order
  op_t mon_e;
  bit  m_inf;
  int  cyc, errors, checks;
  logic [RW-1:0] rob_ctr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic decode_info_t rand_dec();
    decode_info_t d;
    d.pc        = $urandom;
    d.imm       = $urandom;
    d.bp        = 1'($urandom);
    d.bp_addr   = $urandom;
    d.gshare    = 8'($urandom);
    d.pht_value = 2'($urandom);
    return d;
  endfunction

  function automatic logic [127:0] pay(input decode_info_t d, input logic [PW-1:0] a,
                                       input logic [PW-1:0] b, input logic [RW-1:0] r);
    return 128'({d, a, b, r});
  endfunction

  // Monitor: every issue_start must match the oldest expected issue, on time.
  always @(negedge clk) begin
    if (!rst) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL issue_missing: rob %0h due at cycle %0d, none by %0d",
                 exp_q[0].rob, exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      if (issue_start) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL issue_unexpected: rob %0h issued, nothing expected", issue_rob_idx);
        end else begin
          mon_e = exp_q.pop_front();
          chk("issue_cycle", 128'(cyc), 128'(mon_e.cyc));
          chk("issue_payload", pay(issue_decode, issue_prs1, issue_prs2, issue_rob_idx),
              pay(mon_e.dec, mon_e.p1, mon_e.p2, mon_e.rob));
        end
      end
    end
  end

  // One cycle: check model state, drive inputs, advance the model.
  task automatic step(input bit av, input logic [PW-1:0] p1, input logic [PW-1:0] p2,
                      input bit r1, input bit r2, input bit cv, input logic [PW-1:0] cpd,
                      input bit fv, input bit fl);
    op_t o;
    int  sel;
    bit  acc;
    @(negedge clk);
    chk("count", 128'(count), 128'(q.size()));
    chk("inflight", 128'(inflight), 128'(m_inf));
    alloc_valid = av;  alloc_prs1 = p1;  alloc_prs2 = p2;
    alloc_rs1_rdy = r1; alloc_rs2_rdy = r2;
    alloc_rob_idx = rob_ctr; alloc_decode = rand_dec();
    cdb_valid = cv; cdb_pd = cpd; fu_valid = fv; flush = fl;
    #1;
    chk("alloc_ready", 128'(alloc_ready), 128'(!fl && q.size() < DEPTH));
    if (fl) begin
      q.delete();
      m_inf = 0;
      return;
    end
    sel = -1;
    if (!m_inf)
      foreach (q[i]) if (sel < 0 && q[i].r1 && q[i].r2) sel = i;
    acc = av && (q.size() < DEPTH);
    if (sel >= 0) begin
      o = q[sel];
      o.cyc = cyc + 1;
      exp_q.push_back(o);
      q.delete(sel);
      m_inf = 1;
    end else if (fv) begin
      m_inf = 0;
    end
    if (acc) begin
      o.rob = rob_ctr; o.p1 = p1; o.p2 = p2;
      o.r1 = r1 || (p1 == 0);
      o.r2 = r2 || (p2 == 0);
      o.dec = alloc_decode;
      o.cyc = 0;
      q.push_back(o);
      rob_ctr++;
    end
    if (cv)
      foreach (q[i]) begin
        if (q[i].p1 == cpd) q[i].r1 = 1;
        if (q[i].p2 == cpd) q[i].r2 = 1;
      end
  endtask

  task automatic idle(input int n, input bit fv);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, fv, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_count"}, 128'(count), 128'(0));
    chk({tag, "_inflight"}, 128'(inflight), 128'(0));
    chk({tag, "_issue_start"}, 128'(issue_start), 128'(0));
    chk({tag, "_alloc_ready"}, 128'(alloc_ready), 128'(0));
    chk({tag, "_payload"}, pay(issue_decode, issue_prs1, issue_prs2, issue_rob_idx), 128'(0));
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    chk("inflight_before_rst", 128'(inflight), 128'(m_inf));
    alloc_valid = 0; cdb_valid = 0; fu_valid = 0; flush = 0;
    rst = 1;
    #1;
    chk_reset_outputs("async_rst");
    q.delete();
    exp_q.delete();
    m_inf = 0;
    #1 rst = 0;
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; m_inf = 0; rob_ctr = '0;
    alloc_valid = 0; alloc_prs1 = 0; alloc_prs2 = 0; alloc_rs1_rdy = 0; alloc_rs2_rdy = 0;
    alloc_rob_idx = 0; alloc_decode = '0; cdb_valid = 0; cdb_pd = 0; fu_valid = 0; flush = 0;
    #3 chk_reset_outputs("por");
    #9 rst = 0;

    // Basic issue, two-edge latency, inflight until after fu_valid
    step(1, 3, 4, 1, 1, 0, 0, 0, 0);
    idle(3, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2, 0);

    // Wakeup ordering: B overtakes A, A waits for B's completion
    step(1, 5, 0, 0, 0, 0, 0, 0, 0);
    step(1, 6, 7, 1, 1, 0, 0, 0, 0);
    idle(2, 0);
    step(0, 0, 0, 0, 0, 1, 5, 0, 0);
    idle(1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2, 0);

    // Full queue blocks the fifth op; an issue frees a slot
    for (int i = 0; i < 4; i++) step(1, PW'(10 + i), 0, 0, 0, 0, 0, 0, 0);
    step(1, 14, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 10, 0, 0);
    idle(2, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Same-cycle wakeup at allocation
    step(1, 0, 9, 0, 0, 1, 9, 0, 0);
    idle(3, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1, 0);

    // Flush with one in flight and a competing allocation
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0, 1, 1);
    idle(3, 0);

    // Async reset while an op is in flight
    step(1, 0, 0, 1, 1, 0, 0, 0, 0);
    idle(2, 0);
    async_reset();
    idle(2, 0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 99) < 60, PW'($urandom_range(0, 15)), PW'($urandom_range(0, 15)),
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1, PW'($urandom_range(0, 15)),
           $urandom_range(0, 99) < 30, $urandom_range(0, 39) == 0);
      if (n % 500 == 499) async_reset();
    end
    idle(4, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
